// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Control FSM that sequences the instruction fetch unit across one program
//   run. A start pulse clears the PC, the sequencer then waits out the
//   instruction-memory read latency, hands each fetched word to decode and
//   gates PC updates (stall / branch / jump) until the HALT instruction
//   retires. Cycle and retired-instruction counters are kept for readout.
//
//   Parameters
//     MEM_LAT  instr-memory read latency in cycles after a PC change (0..7)
//     CNT_W    width of cycle_cnt_o / instr_cnt_o
//
//   Ports
//     clk_i          clock, all state on rising edge
//     rst_ni         asynchronous active-low reset
//     start_i        pulse: begin a new program run (IDLE / DONE only)
//     halt_op_i      decoder: current instruction is HALT
//     stall_i        datapath hazard: hold PC this cycle
//     br_ctrl_i      decoder: conditional branch
//     jmp_ctrl_i     decoder: unconditional jump
//     zero_ctrl_i    ALU zero flag
//     pc_reset_o     to instr_fetch reset control
//     pc_en_o        PC write enable (advance this cycle)
//     take_br_o      branch/jump select to fetch mux
//     instr_valid_o  instruction word valid for decode this cycle
//     busy_o         run in progress
//     done_o         run finished; held until next start
//     cycle_cnt_o    cycles spent in WAIT+EXEC this run (saturating)
//     instr_cnt_o    instructions retired this run incl. HALT (saturating)
//
//   The control outputs are a same-cycle decode of state and inputs so the
//   fetch unit sees them with zero latency.
module fetch_sequencer #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             halt_op_i,
  input  logic             stall_i,
  input  logic             br_ctrl_i,
  input  logic             jmp_ctrl_i,
  input  logic             zero_ctrl_i,
  output logic             pc_reset_o,
  output logic             pc_en_o,
  output logic             take_br_o,
  output logic             instr_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // wait_q holds the number of WAIT cycles still to go after the current one.
  // The first fetch after a PC clear pays the latency twice: once for the
  // cleared PC to reach the memory address port and once for the read itself,
  // which gives a run length of N*(1+MEM_LAT)+MEM_LAT cycles.
  localparam logic [3:0] STEP_WAIT  = (MEM_LAT > 0) ? 4'(MEM_LAT - 1)     : 4'd0;
  localparam logic [3:0] START_WAIT = (MEM_LAT > 0) ? 4'(2 * MEM_LAT - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  logic pc_reset_s, pc_en_s, take_br_s, instr_valid_s, busy_s, done_s;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // State, wait counter and run counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
      cycle_q <= {CNT_W{1'b0}};
      instr_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  // Next-state, counter updates and same-cycle control decode.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    cycle_d       = cycle_q;
    instr_d       = instr_q;
    pc_reset_s    = 1'b0;
    pc_en_s       = 1'b0;
    take_br_s     = 1'b0;
    instr_valid_s = 1'b0;
    busy_s        = 1'b0;
    done_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        pc_reset_s = 1'b1;
        busy_s     = 1'b1;
        cycle_d    = {CNT_W{1'b0}};
        instr_d    = {CNT_W{1'b0}};
        if (MEM_LAT > 0) begin
          state_d = ST_WAIT;
          wait_d  = START_WAIT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_WAIT: begin
        busy_s  = 1'b1;
        cycle_d = sat_inc(cycle_q);
        if (wait_q == 4'd0) begin
          state_d = ST_EXEC;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_EXEC: begin
        busy_s        = 1'b1;
        instr_valid_s = 1'b1;
        cycle_d       = sat_inc(cycle_q);
        // HALT wins over stall; a stall holds the PC with no new wait.
        if (halt_op_i) begin
          instr_d = sat_inc(instr_q);
          state_d = ST_DONE;
        end else if (stall_i) begin
          state_d = ST_EXEC;
        end else begin
          pc_en_s   = 1'b1;
          take_br_s = (br_ctrl_i & zero_ctrl_i) | jmp_ctrl_i;
          instr_d   = sat_inc(instr_q);
          if (MEM_LAT > 0) begin
            state_d = ST_WAIT;
            wait_d  = STEP_WAIT;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_DONE: begin
        done_s = 1'b1;
        if (start_i) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pc_reset_o    = pc_reset_s;
  assign pc_en_o       = pc_en_s;
  assign take_br_o     = take_br_s;
  assign instr_valid_o = instr_valid_s;
  assign busy_o        = busy_s;
  assign done_o        = done_s;
  assign cycle_cnt_o   = cycle_q;
  assign instr_cnt_o   = instr_q;

endmodule
